osc_freq_monitor: RTL and testbench

Checks an on-chip oscillator or external clock output (RC 1 MHz, crystal, or camera PCLK) before downstream logic relies on it. It samples the monitored clock as an asynchronous data signal in the fabric clock domain and counts its rising edges over a fixed gate window of `CLK` cycles. It reports the count once per window and flags the source locked or faulty against a configured range. It sits next to the oscillator wrapper and feeds the reset sequencer and the status LED logic.

---
 rtl/osc_freq_monitor.sv | 182 ++++++++++++++++++
 tb/tb_osc_freq_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/osc_freq_monitor.sv
// Oscillator frequency monitor: counts rising edges of an asynchronous clock over a fixed gate window.
// Optional range qualification of LOCKED/FAULT is enabled by defining OSC_FREQ_MON_RANGE_CHECK_EN.
module osc_freq_monitor #(
    parameter int unsigned GATE_CYCLES  = 50000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned MIN_COUNT    = 990,
    parameter int unsigned MAX_COUNT    = 1010,
    parameter int unsigned LOCK_WINDOWS = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIG_IN,
    input  logic             EN,
    output logic [CNT_W-1:0] COUNT,
    output logic             COUNT_VALID,
    output logic             SATURATED,
    output logic             LOCKED,
    output logic             FAULT
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned LOCK_W = $clog2(LOCK_WINDOWS) + 1;
    localparam int unsigned ARM_W  = 2;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WINDOWS - 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic [ARM_W-1:0]    arm_q, arm_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CNT_W-1:0]    ecnt_q, ecnt_d;
    logic                wsat_q, wsat_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [CNT_W-1:0]    count_d;
    logic                valid_d, saturated_d, locked_d, fault_d;

    logic                sig_edge_c;
    logic                at_max_c;
    logic [CNT_W-1:0]    inc_cnt_c;
    logic                inc_sat_c;
    logic                window_good_c;

    // Edge detect on the synchronised input; the increment saturates and records the overflow.
    always_comb begin
        sig_edge_c = s2_q & ~s3_q;
        at_max_c   = (ecnt_q == CNT_MAX);
        inc_cnt_c  = (sig_edge_c && !at_max_c) ? ecnt_q + CNT_W'(1) : ecnt_q;
        inc_sat_c  = wsat_q | (sig_edge_c & at_max_c);
    end

`ifdef OSC_FREQ_MON_RANGE_CHECK_EN
    assign window_good_c = !inc_sat_c
                        && (inc_cnt_c >= CNT_W'(MIN_COUNT))
                        && (inc_cnt_c <= CNT_W'(MAX_COUNT));
`else
    logic unused_range_c;
    // Range bounds have no function without the comparators.
    assign unused_range_c = ^{32'(MIN_COUNT), 32'(MAX_COUNT)};
    assign window_good_c  = (inc_cnt_c != '0);
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        arm_d       = arm_q;
        gate_d      = gate_q;
        ecnt_d      = ecnt_q;
        wsat_d      = wsat_q;
        lock_d      = lock_q;
        count_d     = COUNT;
        valid_d     = 1'b0;
        saturated_d = SATURATED;
        locked_d    = LOCKED;
        fault_d     = FAULT;

        case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d = ARM;
                    arm_d   = '0;
                end
            end
            ARM: begin
                arm_d  = arm_q + ARM_W'(1);
                gate_d = '0;
                ecnt_d = '0;
                wsat_d = 1'b0;
                if (arm_q == ARM_LAST) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (gate_q == GATE_LAST) begin
                    gate_d      = '0;
                    ecnt_d      = '0;
                    wsat_d      = 1'b0;
                    count_d     = inc_cnt_c;
                    saturated_d = inc_sat_c;
                    valid_d     = 1'b1;
                    if (window_good_c) begin
                        if (lock_q >= LOCK_LAST) begin
                            locked_d = 1'b1;
                        end else begin
                            lock_d = lock_q + LOCK_W'(1);
                        end
                    end else begin
                        locked_d = 1'b0;
                        lock_d   = '0;
`ifdef OSC_FREQ_MON_RANGE_CHECK_EN
                        if (LOCKED) begin
                            fault_d = 1'b1;
                        end
`endif
                    end
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    ecnt_d = inc_cnt_c;
                    wsat_d = inc_sat_c;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable abandons the partial window but keeps the last reported count.
        if (!EN) begin
            state_d  = IDLE;
            gate_d   = '0;
            ecnt_d   = '0;
            wsat_d   = 1'b0;
            lock_d   = '0;
            valid_d  = 1'b0;
            locked_d = 1'b0;
            fault_d  = 1'b0;
            count_d  = COUNT;
            saturated_d = SATURATED;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            arm_q       <= '0;
            gate_q      <= '0;
            ecnt_q      <= '0;
            wsat_q      <= 1'b0;
            lock_q      <= '0;
            COUNT       <= '0;
            COUNT_VALID <= 1'b0;
            SATURATED   <= 1'b0;
            LOCKED      <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= SIG_IN;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            arm_q       <= arm_d;
            gate_q      <= gate_d;
            ecnt_q      <= ecnt_d;
            wsat_q      <= wsat_d;
            lock_q      <= lock_d;
            COUNT       <= count_d;
            COUNT_VALID <= valid_d;
            SATURATED   <= saturated_d;
            LOCKED      <= locked_d;
            FAULT       <= fault_d;
        end
    end

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Directed bench for osc_freq_monitor; expectations follow OSC_FREQ_MON_RANGE_CHECK_EN when defined.
module tb_osc_freq_monitor;

`ifdef OSC_FREQ_MON_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    localparam int G1 = 100;
    localparam int G2 = 64;

    logic        clk;
    logic        rst, en, sig_in;
    logic [15:0] count;
    logic        valid, sat, locked, fault;

    logic        rst2, en2, sig2;
    logic [3:0]  count2;
    logic        valid2, sat2, locked2, fault2;

    int          mode1;
    int          mode2;
    int          n_vec;
    int          n_err;

    osc_freq_monitor #(
        .GATE_CYCLES(G1), .CNT_W(16), .MIN_COUNT(9), .MAX_COUNT(11), .LOCK_WINDOWS(2)
    ) dut (
        .CLK(clk), .RST(rst), .SIG_IN(sig_in), .EN(en),
        .COUNT(count), .COUNT_VALID(valid), .SATURATED(sat), .LOCKED(locked), .FAULT(fault)
    );

    osc_freq_monitor #(
        .GATE_CYCLES(G2), .CNT_W(4), .MIN_COUNT(1), .MAX_COUNT(15), .LOCK_WINDOWS(2)
    ) dut_sat (
        .CLK(clk), .RST(rst2), .SIG_IN(sig2), .EN(en2),
        .COUNT(count2), .COUNT_VALID(valid2), .SATURATED(sat2), .LOCKED(locked2), .FAULT(fault2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitored clock for dut: 0 = 10 clk period, 1 = 5 clk period, 2 = stuck high.
    initial begin
        sig_in = 1'b0;
        #3;
        forever begin
            case (mode1)
                0:       begin sig_in = 1'b1; #50; sig_in = 1'b0; #50; end
                1:       begin sig_in = 1'b1; #30; sig_in = 1'b0; #20; end
                default: begin sig_in = 1'b1; #10; end
            endcase
        end
    end

    // Monitored clock for dut_sat: 0 = 4 clk period, 1 = 8 clk period.
    initial begin
        sig2 = 1'b0;
        #3;
        forever begin
            if (mode2 == 0) begin sig2 = 1'b1; #20; sig2 = 1'b0; #20; end
            else            begin sig2 = 1'b1; #40; sig2 = 1'b0; #40; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the selected COUNT_VALID is seen; cyc is posedges consumed.
    task automatic wait_valid(input bit sel, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(sel ? valid2 : valid) && cyc < budget);
        chk("valid_seen", 32'(sel ? valid2 : valid), 1);
    endtask

    initial begin
        int cyc;
        int pulses;
        n_vec = 0;
        n_err = 0;
        mode1 = 0;
        mode2 = 0;
        rst   = 1'b1;
        en    = 1'b0;
        rst2  = 1'b1;
        en2   = 1'b0;

        step(4);
        chk("rst_count",  32'(count), 0);
        chk("rst_valid",  32'(valid), 0);
        chk("rst_sat",    32'(sat),   0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_fault",  32'(fault), 0);
        rst = 1'b0;
        step(2);

        // First window after enable
        en = 1'b1;
        wait_valid(1'b0, 400, cyc);
        chk("first_latency", 32'(cyc), G1 + 4);
        chk("w1_count",  32'(count), 10);
        chk("w1_sat",    32'(sat), 0);
        chk("w1_locked", 32'(locked), 0);
        step(1);
        chk("valid_one_cycle", 32'(valid), 0);

        wait_valid(1'b0, 400, cyc);
        chk("period", 32'(cyc), G1 - 1);
        chk("w2_count",  32'(count), 10);
        chk("w2_locked", 32'(locked), 1);
        chk("w2_fault",  32'(fault), 0);

        // Frequency raised after lock
        mode1 = 1;
        wait_valid(1'b0, 400, cyc);
        wait_valid(1'b0, 400, cyc);
        chk("fast_count",  32'(count), 20);
        chk("fast_locked", 32'(locked), RC ? 0 : 1);
        chk("fast_fault",  32'(fault),  RC ? 1 : 0);

        // Frequency restored: fault remains sticky
        mode1 = 0;
        wait_valid(1'b0, 400, cyc);
        wait_valid(1'b0, 400, cyc);
        chk("back_count", 32'(count), 10);
        chk("back_fault", 32'(fault), RC ? 1 : 0);

        // Disable mid-window
        step(40);
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        chk("dis_no_valid", 32'(pulses), 0);
        chk("dis_count",    32'(count), 10);
        chk("dis_locked",   32'(locked), 0);
        chk("dis_fault",    32'(fault), 0);

        en = 1'b1;
        wait_valid(1'b0, 400, cyc);
        chk("reen_latency", 32'(cyc), G1 + 4);
        chk("reen_count",   32'(count), 10);
        wait_valid(1'b0, 400, cyc);
        chk("reen_locked",  32'(locked), 1);

        // Reset mid-window while locked
        step(30);
        rst = 1'b1;
        step(1);
        chk("mrst_count",  32'(count), 0);
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_fault",  32'(fault), 0);
        chk("mrst_valid",  32'(valid), 0);
        rst = 1'b0;
        wait_valid(1'b0, 400, cyc);
        chk("mrst_latency", 32'(cyc), G1 + 4);
        chk("mrst_count2",  32'(count), 10);

        // Stuck-high source
        en = 1'b0;
        mode1 = 2;
        step(20);
        en = 1'b1;
        wait_valid(1'b0, 400, cyc);
        chk("stuck_count1", 32'(count), 0);
        wait_valid(1'b0, 400, cyc);
        chk("stuck_count2", 32'(count), 0);
        chk("stuck_locked", 32'(locked), 0);
        chk("stuck_fault",  32'(fault), 0);

        // Counter saturation on the narrow instance
        rst2 = 1'b0;
        step(2);
        en2 = 1'b1;
        wait_valid(1'b1, 300, cyc);
        chk("sat_latency", 32'(cyc), G2 + 4);
        chk("sat_count1",  32'(count2), 15);
        chk("sat_flag1",   32'(sat2), 1);
        wait_valid(1'b1, 300, cyc);
        chk("sat_count2",  32'(count2), 15);
        chk("sat_flag2",   32'(sat2), 1);
        chk("sat_locked",  32'(locked2), RC ? 0 : 1);
        chk("sat_fault",   32'(fault2), 0);
        mode2 = 1;
        wait_valid(1'b1, 300, cyc);
        wait_valid(1'b1, 300, cyc);
        chk("unsat_count", 32'(count2), 8);
        chk("unsat_flag",  32'(sat2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
